// File: rtl/wb_req_slice.sv
// wb_req_slice: pipelined Wishbone request slice with a two-entry skid buffer
// that registers STB and payload; terminations and read data pass straight through.
module wb_req_slice #(
  parameter int ADR_WIDTH  = 16,
  parameter int DAT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TGA_WIDTH  = 1,
  parameter int TGC_WIDTH  = 1,
  parameter int TGRD_WIDTH = 1,
  parameter int TGWD_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  sync_rst_i,
  input  logic                  itf_cyc_i,
  input  logic                  itf_stb_i,
  input  logic                  itf_we_i,
  input  logic                  itf_lock_i,
  input  logic [SEL_WIDTH-1:0]  itf_sel_i,
  input  logic [ADR_WIDTH-1:0]  itf_adr_i,
  input  logic [DAT_WIDTH-1:0]  itf_dat_i,
  input  logic [TGA_WIDTH-1:0]  itf_tga_i,
  input  logic [TGC_WIDTH-1:0]  itf_tgc_i,
  input  logic [TGWD_WIDTH-1:0] itf_tgd_i,
  output logic                  itf_ack_o,
  output logic                  itf_err_o,
  output logic                  itf_rty_o,
  output logic                  itf_stall_o,
  output logic [DAT_WIDTH-1:0]  itf_dat_o,
  output logic [TGRD_WIDTH-1:0] itf_tgd_o,
  output logic                  tgt_cyc_o,
  output logic                  tgt_stb_o,
  output logic                  tgt_we_o,
  output logic                  tgt_lock_o,
  output logic [SEL_WIDTH-1:0]  tgt_sel_o,
  output logic [ADR_WIDTH-1:0]  tgt_adr_o,
  output logic [DAT_WIDTH-1:0]  tgt_dat_o,
  output logic [TGA_WIDTH-1:0]  tgt_tga_o,
  output logic [TGC_WIDTH-1:0]  tgt_tgc_o,
  output logic [TGWD_WIDTH-1:0] tgt_tgd_o,
  input  logic                  tgt_ack_i,
  input  logic                  tgt_err_i,
  input  logic                  tgt_rty_i,
  input  logic                  tgt_stall_i,
  input  logic [DAT_WIDTH-1:0]  tgt_dat_i,
  input  logic [TGRD_WIDTH-1:0] tgt_tgd_i
);
  localparam int PW = 1 + SEL_WIDTH + ADR_WIDTH + DAT_WIDTH + TGA_WIDTH + TGC_WIDTH + TGWD_WIDTH;
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b10} state_t;
  state_t state;
  logic [PW-1:0] m, s, in_p;
  logic acc, take, rst;
  assign in_p = {itf_we_i, itf_sel_i, itf_adr_i, itf_dat_i, itf_tga_i, itf_tgc_i, itf_tgd_i};
  assign {tgt_we_o, tgt_sel_o, tgt_adr_o, tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o} = m;
  assign rst         = async_rst_i | sync_rst_i;
  assign itf_stall_o = state == FULL;
  assign tgt_stb_o   = (state != EMPTY) & itf_cyc_i;
  assign tgt_cyc_o   = itf_cyc_i & ~rst;
  assign tgt_lock_o  = itf_lock_i & itf_cyc_i & ~rst;
  assign acc         = itf_cyc_i & itf_stb_i & ~itf_stall_o;
  assign take        = tgt_stb_o & ~tgt_stall_i;
  assign itf_ack_o   = tgt_ack_i;
  assign itf_err_o   = tgt_err_i;
  assign itf_rty_o   = tgt_rty_i;
  assign itf_dat_o   = tgt_dat_i;
  assign itf_tgd_o   = tgt_tgd_i;
  // Dropping CYC discards anything buffered; payload is kept but no longer strobed.
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state <= EMPTY;
      m     <= '0;
      s     <= '0;
    end else if (sync_rst_i) begin
      state <= EMPTY;
      m     <= '0;
      s     <= '0;
    end else if (!itf_cyc_i) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          m     <= in_p;
          state <= ONE;
        end
        ONE: begin
          if (acc && take) m <= in_p;
          if (acc && !take) s <= in_p;
          state <= (acc && !take) ? FULL : (!acc && take) ? EMPTY : ONE;
        end
        FULL: if (take) begin
          m     <= s;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_req_slice.sv
// tb_wb_req_slice: table-driven check of streaming, skid, abort and reset behaviour.
module tb_wb_req_slice;
  logic        clk_i = 0, async_rst_i = 1, sync_rst_i = 0;
  logic        itf_cyc_i = 1, itf_stb_i = 1, itf_we_i = 0, itf_lock_i = 1;
  logic [1:0]  itf_sel_i = 2'b11;
  logic [15:0] itf_adr_i = 16'h00FF, itf_dat_i = 16'h1234;
  logic [0:0]  itf_tga_i = 1'b1, itf_tgc_i = 1'b1, itf_tgd_i = 1'b1;
  logic        itf_ack_o, itf_err_o, itf_rty_o, itf_stall_o;
  logic [15:0] itf_dat_o;
  logic [0:0]  itf_tgd_o;
  logic        tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o;
  logic [1:0]  tgt_sel_o;
  logic [15:0] tgt_adr_o, tgt_dat_o;
  logic [0:0]  tgt_tga_o, tgt_tgc_o, tgt_tgd_o;
  logic        tgt_ack_i = 0, tgt_err_i = 0, tgt_rty_i = 0, tgt_stall_i = 0;
  logic [15:0] tgt_dat_i = 16'h0;
  logic [0:0]  tgt_tgd_i = 1'b0;
  int n_tests = 0, n_fail = 0;

  wb_req_slice dut (
    .clk_i(clk_i), .async_rst_i(async_rst_i), .sync_rst_i(sync_rst_i),
    .itf_cyc_i(itf_cyc_i), .itf_stb_i(itf_stb_i), .itf_we_i(itf_we_i), .itf_lock_i(itf_lock_i),
    .itf_sel_i(itf_sel_i), .itf_adr_i(itf_adr_i), .itf_dat_i(itf_dat_i),
    .itf_tga_i(itf_tga_i), .itf_tgc_i(itf_tgc_i), .itf_tgd_i(itf_tgd_i),
    .itf_ack_o(itf_ack_o), .itf_err_o(itf_err_o), .itf_rty_o(itf_rty_o), .itf_stall_o(itf_stall_o),
    .itf_dat_o(itf_dat_o), .itf_tgd_o(itf_tgd_o),
    .tgt_cyc_o(tgt_cyc_o), .tgt_stb_o(tgt_stb_o), .tgt_we_o(tgt_we_o), .tgt_lock_o(tgt_lock_o),
    .tgt_sel_o(tgt_sel_o), .tgt_adr_o(tgt_adr_o), .tgt_dat_o(tgt_dat_o),
    .tgt_tga_o(tgt_tga_o), .tgt_tgc_o(tgt_tgc_o), .tgt_tgd_o(tgt_tgd_o),
    .tgt_ack_i(tgt_ack_i), .tgt_err_i(tgt_err_i), .tgt_rty_i(tgt_rty_i), .tgt_stall_i(tgt_stall_i),
    .tgt_dat_i(tgt_dat_i), .tgt_tgd_i(tgt_tgd_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        cyc, stb, stall;
    logic [15:0] adr;
    logic        e_stb, e_stall;
    logic [15:0] e_adr;
  } vec_t;
  vec_t v[20];

  function automatic vec_t mk(logic cyc, logic stb, logic stall, logic [15:0] adr,
                              logic e_stb, logic e_stall, logic [15:0] e_adr);
    mk = '{cyc, stb, stall, adr, e_stb, e_stall, e_adr};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(logic cyc, logic stb, logic stall, logic [15:0] adr);
    itf_cyc_i = cyc; itf_stb_i = stb; tgt_stall_i = stall;
    itf_adr_i = adr; itf_dat_i = adr ^ 16'h5A00; itf_we_i = adr[0];
  endtask

  initial begin
    // streaming 0x10..0x13
    v[0]  = mk(1, 1, 0, 16'h10, 0, 0, 16'h0);
    v[1]  = mk(1, 1, 0, 16'h11, 1, 0, 16'h10);
    v[2]  = mk(1, 1, 0, 16'h12, 1, 0, 16'h11);
    v[3]  = mk(1, 1, 0, 16'h13, 1, 0, 16'h12);
    v[4]  = mk(1, 0, 0, 16'h0,  1, 0, 16'h13);
    v[5]  = mk(1, 0, 0, 16'h0,  0, 0, 16'h0);
    // skid: 0x20 held in M while stalled, 0x21 in S, 0x22 held by initiator
    v[6]  = mk(1, 1, 0, 16'h20, 0, 0, 16'h0);
    v[7]  = mk(1, 1, 1, 16'h21, 1, 0, 16'h20);
    v[8]  = mk(1, 1, 1, 16'h22, 1, 1, 16'h20);
    v[9]  = mk(1, 1, 1, 16'h22, 1, 1, 16'h20);
    v[10] = mk(1, 1, 0, 16'h22, 1, 1, 16'h20);
    v[11] = mk(1, 1, 0, 16'h22, 1, 0, 16'h21);
    v[12] = mk(1, 0, 0, 16'h0,  1, 0, 16'h22);
    v[13] = mk(0, 0, 0, 16'h0,  0, 0, 16'h0);
    // abort while FULL, then a fresh cycle with 0x30
    v[14] = mk(1, 1, 0, 16'h40, 0, 0, 16'h0);
    v[15] = mk(1, 1, 1, 16'h41, 1, 0, 16'h40);
    v[16] = mk(0, 0, 1, 16'h0,  0, 1, 16'h0);
    v[17] = mk(1, 1, 0, 16'h30, 0, 0, 16'h0);
    v[18] = mk(1, 0, 0, 16'h0,  1, 0, 16'h30);
    v[19] = mk(1, 0, 0, 16'h0,  0, 0, 16'h0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("rst_cyc", tgt_cyc_o, 0);
      check("rst_lock", tgt_lock_o, 0);
      check("rst_stb", tgt_stb_o, 0);
      check("rst_stall", itf_stall_o, 0);
    end
    @(posedge clk_i);
    #1 async_rst_i = 0; itf_cyc_i = 0; itf_stb_i = 0;
    @(negedge clk_i);
    check("post_rst_cyc", tgt_cyc_o, 0);
    check("post_rst_stb", tgt_stb_o, 0);
    check("post_rst_stall", itf_stall_o, 0);
    check("post_rst_adr", tgt_adr_o, 0);
    check("post_rst_dat", tgt_dat_o, 0);
    check("post_rst_lock", tgt_lock_o, 0);
    step();
    itf_lock_i = 0;

    for (int i = 0; i < 20; i++) begin
      drive(v[i].cyc, v[i].stb, v[i].stall, v[i].adr);
      @(negedge clk_i);
      check($sformatf("v%0d_stb", i), tgt_stb_o, v[i].e_stb);
      check($sformatf("v%0d_stall", i), itf_stall_o, v[i].e_stall);
      check($sformatf("v%0d_cyc", i), tgt_cyc_o, v[i].cyc);
      if (v[i].e_stb) begin
        check($sformatf("v%0d_adr", i), tgt_adr_o, v[i].e_adr);
        check($sformatf("v%0d_dat", i), tgt_dat_o, v[i].e_adr ^ 16'h5A00);
        check($sformatf("v%0d_we", i), tgt_we_o, v[i].e_adr[0]);
      end
      step();
    end

    // lock gating by cyc
    itf_lock_i = 1; drive(1, 0, 0, 16'h0); #1;
    check("lock_on", tgt_lock_o, 1);
    itf_cyc_i = 0; #1;
    check("lock_nocyc", tgt_lock_o, 0);
    itf_lock_i = 0;

    // async reset while FULL clears immediately
    drive(1, 1, 0, 16'h50); step();
    drive(1, 1, 1, 16'h51); step();
    check("pre_arst_full", itf_stall_o, 1);
    async_rst_i = 1; #1;
    check("arst_stall", itf_stall_o, 0);
    check("arst_stb", tgt_stb_o, 0);
    check("arst_cyc", tgt_cyc_o, 0);
    check("arst_adr", tgt_adr_o, 0);
    step();
    async_rst_i = 0; drive(1, 0, 0, 16'h0);
    @(negedge clk_i);
    check("arst_no_stale", tgt_stb_o, 0);
    step();

    // sync reset from ONE
    drive(1, 1, 1, 16'h60); step();
    check("pre_srst_stb", tgt_stb_o, 1);
    sync_rst_i = 1; itf_stb_i = 0; #1;
    check("srst_cyc", tgt_cyc_o, 0);
    step();
    check("srst_stb", tgt_stb_o, 0);
    check("srst_adr", tgt_adr_o, 0);
    sync_rst_i = 0; drive(0, 0, 0, 16'h0); step();

    // response pass-through
    tgt_err_i = 1; tgt_dat_i = 16'hBEEF; tgt_tgd_i = 1; #1;
    check("pt_err", itf_err_o, 1);
    check("pt_dat", itf_dat_o, 16'hBEEF);
    check("pt_tgd", itf_tgd_o, 1);
    check("pt_ack0", itf_ack_o, 0);
    tgt_err_i = 0; tgt_ack_i = 1; tgt_rty_i = 1; tgt_dat_i = 16'h1357; #1;
    check("pt_ack", itf_ack_o, 1);
    check("pt_rty", itf_rty_o, 1);
    check("pt_err0", itf_err_o, 0);
    check("pt_dat2", itf_dat_o, 16'h1357);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
